// File: rtl/microseq_pkg.sv
// Shared definitions for the microsequencer: next-address op encodings.
// Optional case-branch OR behaviour is selected by MICROSEQ_CASE_OR_EN.
package microseq_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_JZ   = 4'd0;
  localparam logic [OP_W-1:0] OP_CJS  = 4'd1;
  localparam logic [OP_W-1:0] OP_JMAP = 4'd2;
  localparam logic [OP_W-1:0] OP_CJP  = 4'd3;
  localparam logic [OP_W-1:0] OP_PUSH = 4'd4;
  localparam logic [OP_W-1:0] OP_CRTN = 4'd5;
  localparam logic [OP_W-1:0] OP_RFCT = 4'd6;
  localparam logic [OP_W-1:0] OP_LDCT = 4'd7;
  localparam logic [OP_W-1:0] OP_CONT = 4'd8;
  localparam logic [OP_W-1:0] OP_LOOP = 4'd9;
  localparam logic [OP_W-1:0] OP_TWB  = 4'd10;

endpackage

// File: rtl/microseq_stack.sv
// Return/loop LIFO for the microsequencer with combinational top-of-stack and
// a single-cycle err pulse for a discarded push or a pop/peek on an empty stack.
module microseq_stack #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic              peek,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] tos,
  output logic              full,
  output logic              empty,
  output logic              err
);

  logic [ADDR_W-1:0]      mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0]      mem_d [STACK_DEPTH];
  logic [SP_W-1:0]        sp_q;
  logic [SP_W-1:0]        sp_d;
  logic [IDX_W-1:0]       wr_idx;
  logic [IDX_W-1:0]       tos_idx;
  logic [STACK_DEPTH-1:0] entry_we;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (sp_q == SP_W'(STACK_DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign err     = (push & full) | ((pop | peek) & empty);

  assign wr_idx  = IDX_W'(sp_q);
  assign tos_idx = IDX_W'(sp_q - 1'b1);
  // An empty stack reads as address 0 rather than stale contents.
  assign tos     = empty ? '0 : mem_q[tos_idx];

  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_we
      assign entry_we[gi] = do_push & (wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      mem_d[i] = entry_we[i] ? din : mem_q[i];
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (clr) begin
      sp_d = '0;
    end else if (do_push) begin
      sp_d = sp_q + 1'b1;
    end else if (do_pop) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

endmodule

// File: rtl/microsequencer_gen.sv
// Parametrised microprogram sequencer: next-address mux, uPC, loop counter, stack.
// Define MICROSEQ_CASE_OR_EN to OR or_in into the branch field for CJS/CJP/TWB.
module microsequencer_gen
  import microseq_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  input  logic              cc,
  input  logic [ADDR_W-1:0] d_in,
  input  logic [ADDR_W-1:0] map_in,
  input  logic [ADDR_W-1:0] or_in,
  input  logic              hold,
  output logic [ADDR_W-1:0] y,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] ctr_q, ctr_d, ctr_op;
  logic              stack_err_q, stack_err_d;
  logic [ADDR_W-1:0] d_eff;
  logic [ADDR_W-1:0] tos;
  logic              push, pop, peek, clr;
  logic              active;
  logic              stk_err;
  logic              ctr_nz;

`ifdef MICROSEQ_CASE_OR_EN
  assign d_eff = d_in | or_in;
`else
  logic unused_or_in;
  assign unused_or_in = ^or_in;
  assign d_eff        = d_in;
`endif

  assign ctr_nz = (ctr_q != '0);
  // Stack side effects only happen on edges that actually commit state.
  assign active = ~reset & ~hold;

  always_comb begin
    y      = upc_q;
    ctr_op = ctr_q;
    push   = 1'b0;
    pop    = 1'b0;
    peek   = 1'b0;
    clr    = 1'b0;
    case (op)
      OP_JZ: begin
        y   = '0;
        clr = 1'b1;
      end
      OP_CJS: begin
        if (cc) begin
          y    = d_eff;
          push = 1'b1;
        end
      end
      OP_JMAP: y = map_in;
      OP_CJP: begin
        if (cc) y = d_eff;
      end
      OP_PUSH: begin
        push = 1'b1;
        if (cc) ctr_op = d_in;
      end
      OP_CRTN: begin
        if (cc) begin
          y   = tos;
          pop = 1'b1;
        end
      end
      OP_RFCT: begin
        if (ctr_nz) begin
          y      = tos;
          peek   = 1'b1;
          ctr_op = ctr_q - 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      OP_LDCT: ctr_op = d_in;
      OP_LOOP: begin
        if (cc) begin
          pop = 1'b1;
        end else begin
          y    = tos;
          peek = 1'b1;
        end
      end
      OP_TWB: begin
        if (ctr_nz) begin
          ctr_op = ctr_q - 1'b1;
          if (cc) y = d_eff;
        end else begin
          pop = 1'b1;
        end
      end
      default: y = upc_q;
    endcase
    if (reset) y = '0;
  end

  microseq_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .clr   (clr & active),
    .push  (push & active),
    .pop   (pop & active),
    .peek  (peek & active),
    .din   (upc_q),
    .tos   (tos),
    .full  (stack_full),
    .empty (stack_empty),
    .err   (stk_err)
  );

  always_comb begin
    upc_d       = hold ? upc_q : y + 1'b1;
    ctr_d       = hold ? ctr_q : ctr_op;
    stack_err_d = stack_err_q | stk_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      upc_q       <= '0;
      ctr_q       <= '0;
      stack_err_q <= 1'b0;
    end else begin
      upc_q       <= upc_d;
      ctr_q       <= ctr_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign stack_err = stack_err_q;

endmodule

// File: tb/tb_microsequencer_gen.sv
// Directed self-checking bench for microsequencer_gen (default 11-bit, depth 4).
// Case-OR expectation follows MICROSEQ_CASE_OR_EN when the bench is built with it.
module tb_microsequencer_gen;
  import microseq_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic        cc;
  logic [10:0] d_in;
  logic [10:0] map_in;
  logic [10:0] or_in;
  logic        hold;
  logic [10:0] y;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_err;

  int n_cmp = 0;
  int n_bad = 0;

  microsequencer_gen #(.ADDR_W(11), .STACK_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .op          (op),
    .cc          (cc),
    .d_in        (d_in),
    .map_in      (map_in),
    .or_in       (or_in),
    .hold        (hold),
    .y           (y),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Apply one microinstruction, check the combinational y, then take the edge.
  task automatic step(input logic [3:0] o, input logic c, input logic [10:0] d,
                      input logic [10:0] exp_y, input string tag);
    op   = o;
    cc   = c;
    d_in = d;
    #1;
    check(tag, {21'd0, y}, {21'd0, exp_y});
    @(posedge clock);
    #1;
  endtask

  task automatic flags(input string tag, input logic e, input logic f, input logic r);
    check({tag, ".empty"}, {31'd0, stack_empty}, {31'd0, e});
    check({tag, ".full"},  {31'd0, stack_full},  {31'd0, f});
    check({tag, ".err"},   {31'd0, stack_err},   {31'd0, r});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [10:0] or_exp;
    reset = 1'b1; op = OP_CONT; cc = 1'b0; d_in = '0;
    map_in = '0; or_in = '0; hold = 1'b0;
    #1;
    check("reset_y", {21'd0, y}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    flags("reset", 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) step(OP_CONT, 1'b0, 11'h000, 11'(i), "cont_seq");
    flags("cont", 1'b1, 1'b0, 1'b0);

    step(OP_CJP, 1'b0, 11'h3FF, 11'h005, "cjp_fail");
    step(OP_CJP, 1'b1, 11'h010, 11'h010, "cjp_pass");
    step(OP_CJS, 1'b1, 11'h200, 11'h200, "cjs_call");
    flags("cjs", 1'b0, 1'b0, 1'b0);
    step(OP_CRTN, 1'b1, 11'h000, 11'h011, "crtn_ret");
    flags("crtn", 1'b1, 1'b0, 1'b0);

    // Counted loop: LDCT 3, PUSH, then a single-word RFCT body at 0x021.
    step(OP_CJP,  1'b1, 11'h01F, 11'h01F, "to_loop");
    step(OP_LDCT, 1'b0, 11'h003, 11'h020, "ldct3");
    step(OP_PUSH, 1'b0, 11'h7FF, 11'h021, "push_loop");
    for (int i = 0; i < 3; i++) step(OP_RFCT, 1'b0, 11'h000, 11'h021, "rfct_body");
    step(OP_RFCT, 1'b0, 11'h000, 11'h022, "rfct_exit");
    flags("rfct", 1'b1, 1'b0, 1'b0);

    step(OP_PUSH, 1'b1, 11'h002, 11'h023, "push_ld2");
    step(OP_TWB,  1'b0, 11'h300, 11'h024, "twb_fail");
    step(OP_TWB,  1'b1, 11'h300, 11'h300, "twb_pass");
    step(OP_TWB,  1'b1, 11'h300, 11'h301, "twb_zero");
    flags("twb", 1'b1, 1'b0, 1'b0);
    check("twb_ctr", {21'd0, dut.ctr_q}, 32'd0);

    step(OP_PUSH, 1'b0, 11'h000, 11'h302, "push_lp");
    step(OP_LOOP, 1'b0, 11'h000, 11'h302, "loop_fail");
    step(OP_LOOP, 1'b1, 11'h000, 11'h303, "loop_pass");
    flags("loop", 1'b1, 1'b0, 1'b0);

    map_in = 11'h555;
    step(OP_JMAP, 1'b0, 11'h000, 11'h555, "jmap");
    map_in = '0;

    for (int i = 0; i < 4; i++) step(OP_CJS, 1'b1, 11'h100, 11'h100, "cjs_fill");
    flags("fill4", 1'b0, 1'b1, 1'b0);
    step(OP_CJS, 1'b1, 11'h040, 11'h040, "cjs_over");
    flags("over", 1'b0, 1'b1, 1'b1);

    step(OP_JZ, 1'b0, 11'h000, 11'h000, "jz");
    flags("jz", 1'b1, 1'b0, 1'b1);

    reset = 1'b1;
    step(OP_CJP, 1'b1, 11'h0AB, 11'h000, "reset_mid");
    reset = 1'b0;
    flags("rst2", 1'b1, 1'b0, 1'b0);

    step(OP_CRTN, 1'b1, 11'h000, 11'h000, "crtn_empty");
    flags("under", 1'b1, 1'b0, 1'b1);

    step(OP_LDCT, 1'b0, 11'h005, 11'h001, "ldct5");
    hold = 1'b1;
    step(OP_CONT, 1'b0, 11'h000, 11'h002, "hold_cont");
    step(OP_CJP,  1'b1, 11'h2AA, 11'h2AA, "hold_cjp");
    step(OP_LDCT, 1'b0, 11'h077, 11'h002, "hold_ldct");
    check("hold_ctr", {21'd0, dut.ctr_q}, 32'd5);
    hold = 1'b0;
    step(OP_CONT, 1'b0, 11'h000, 11'h002, "after_hold");

    step(OP_CJP,  1'b1, 11'h7FF, 11'h7FF, "cjp_top");
    step(OP_CONT, 1'b0, 11'h000, 11'h000, "upc_wrap");
    step(4'hF,    1'b0, 11'h000, 11'h001, "undef_op");

`ifdef MICROSEQ_CASE_OR_EN
    or_exp = 11'h103;
`else
    or_exp = 11'h100;
`endif
    or_in = 11'h003;
    step(OP_CJP, 1'b1, 11'h100, or_exp, "case_or");
    or_in = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
